palabra_a_bytes: RTL and testbench
==================================

# palabra_a_bytes

Transmit-side counterpart of the receive byte assembler: accepts 32-bit words from the core and splits each into four bytes, LSB first, for the UART transmitter. A one-word holding buffer lets the core hand over the next word while the current one is still being sent. Each byte uses a start/busy handshake with the UART TX. A timeout flags a transmitter that never acknowledges.

## Interface
Parameters:
- NBYTES, 4: bytes per word; word width is 8*NBYTES.
- ACK_WAIT, 15: maximum cycles to wait for tx_busy to rise after tx_start; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  8*NBYTES  word to send; byte 0 = data_in[7:0].
- data_valid  in  1  word offer; accepted on a rising edge when data_valid && ready.
- ready  out  1  holding buffer empty; combinational, equals !hold_full.
- tx_dato  out  8  byte presented to the UART TX.
- tx_start  out  1  one-cycle registered request to the UART TX.
- tx_busy  in  1  UART TX is sending a byte.
- busy  out  1  serializer is not in IDLE.
- flat_comple  out  1  one-cycle pulse after the last byte of a word finishes.
- err  out  1  sticky acknowledge-timeout flag.

## Operation
- Storage:
  - hold register plus hold_full flag.
  - shift register.
  - byte_idx counter, width clog2(NBYTES).
  - ack counter, width clog2(ACK_WAIT+1).
- Accept: on an edge with data_valid && ready, hold <= data_in and hold_full <= 1. A word offered while ready=0 is ignored; the core must hold it.
- State machine, states IDLE, START, WAIT_ACK, WAIT_IDLE:
  - IDLE, hold_full=1: shift <= hold, hold_full <= 0, byte_idx <= 0, go to START.
  - IDLE, hold_full=0: stay in IDLE.
  - START: tx_start=1 for this cycle only. tx_dato = shift byte byte_idx. Clear the ack counter. Go to WAIT_ACK.
  - WAIT_ACK, tx_busy=1: go to WAIT_IDLE.
  - WAIT_ACK, tx_busy=0: increment the ack counter. When it reaches ACK_WAIT: set err, abandon the rest of the word, go to IDLE. flat_comple is not pulsed.
  - WAIT_IDLE, tx_busy=0 and byte_idx==NBYTES-1: pulse flat_comple, go to IDLE.
  - WAIT_IDLE, tx_busy=0 otherwise: byte_idx <= byte_idx+1, go to START.
  - WAIT_IDLE, tx_busy=1: stay in WAIT_IDLE.
- tx_dato holds shift[8*byte_idx +: 8] from START until the state leaves WAIT_IDLE. In IDLE it keeps its last value.
- busy = (state != IDLE).
- err clears only on rst. It does not block later words.
- Accepting into hold is independent of the state machine. In IDLE, hold can be accepted on one edge and moved to shift on the next.

## Timing
- Reset values:
  - state=IDLE, hold_full=0, so ready=1.
  - tx_start=0, tx_dato=8'h00, busy=0, flat_comple=0, err=0.
  - shift, hold, byte_idx and ack counter are all 0.
- Reset has priority over every other event. Asserting rst mid-word:
  - drops the in-flight word and any held word;
  - drives tx_start low from the next edge;
  - does not pulse flat_comple.
- Latency from an idle block: data_valid accepted at edge E0 → moved to shift at E1 → tx_start high in the cycle after E1 (between E1 and E2).
- tx_start is never high for two consecutive cycles. At least two cycles separate successive tx_start pulses.
- With a TX that raises busy the cycle after tx_start and holds it for B cycles, each byte takes B+2 cycles, start to next start.
- flat_comple goes high the cycle after the edge that sees tx_busy=0 on the last byte.
- A held word starts no earlier than one cycle after flat_comple, because IDLE lasts at least one cycle. There is no back-to-back overlap.
- tx_busy is sampled only in WAIT_ACK and WAIT_IDLE. tx_busy high during IDLE or START is ignored.
- Timeout: err rises ACK_WAIT cycles after entering WAIT_ACK, counting cycles with tx_busy=0.

## Test plan
- Single word: rst, then data_in=32'hDDCCBBAA with data_valid one cycle. TX model has busy 3 cycles after each start.
  - Required: tx_start pulses with tx_dato AA, BB, CC, DD in that order.
  - Then exactly one flat_comple pulse; busy returns to 0; err=0.
- Buffering: offer 32'h04030201, then 32'h08070605 on the next cycle.
  - Required: ready=0 after the second accept until the first word moves to shift (after that it is 1).
  - Output byte order 01..08, two flat_comple pulses.
  - A third word offered while ready=0 must not be transmitted.
- Timeout: TX model never raises busy.
  - Required: one tx_start with byte AA, then err=1 exactly ACK_WAIT cycles later.
  - No flat_comple; block returns to IDLE.
  - The next word still transmits, and err stays 1.
- Reset mid-word: assert rst while in WAIT_IDLE of byte 2, with a word in hold.
  - Required: after the edge, all outputs are at reset values and ready=1.
  - No further tx_start until a new word is accepted.
- Slow and immediate TX: busy held for 20 cycles on byte 1; busy deasserted within one cycle on the other bytes.
  - Required: tx_dato stays stable across the whole byte.
  - No duplicated or skipped bytes; flat_comple occurs once.
- Spurious busy: tx_busy=1 while idle, then a word is offered.
  - Required: no flat_comple and no state change before the first tx_start.
  - Handshake proceeds normally from START.

Source files
------------

// File: rtl/palabra_a_bytes_if.sv
// Word-to-byte serializer bus: core word offer on one side, UART TX byte
// handshake on the other, plus status flags.
`timescale 1ns/1ps
interface palabra_a_bytes_if #(
    parameter int NBYTES = 4
);
    logic [8*NBYTES-1:0] data_in;
    logic                data_valid;
    logic                ready;
    logic [7:0]          tx_dato;
    logic                tx_start;
    logic                tx_busy;
    logic                busy;
    logic                flat_comple;
    logic                err;

    // Environment side: the core offering words and the UART TX answering.
    modport master (
        output data_in, data_valid, tx_busy,
        input  ready, tx_dato, tx_start, busy, flat_comple, err
    );

    // Serializer side.
    modport slave (
        input  data_in, data_valid, tx_busy,
        output ready, tx_dato, tx_start, busy, flat_comple, err
    );
endinterface

// File: rtl/palabra_a_bytes.sv
// Splits words from the core into bytes, LSB first, for the UART TX.
// A one-word holding buffer decouples the core from the byte serializer;
// each byte is handed over with a start/busy handshake guarded by a timeout.
`timescale 1ns/1ps
module palabra_a_bytes #(
    parameter int NBYTES   = 4,
    parameter int ACK_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    palabra_a_bytes_if.slave bus
);
    localparam int WORD_W = 8 * NBYTES;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int ACK_W  = $clog2(ACK_WAIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    // The counter is compared before it increments, so the last count is
    // ACK_WAIT-1; err then rises ACK_WAIT cycles after entering WAIT_ACK.
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_IDLE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] hold;
    logic              hold_full;
    logic [WORD_W-1:0] shift;
    logic [IDX_W-1:0]  byte_idx;
    logic [ACK_W-1:0]  ack_cnt;
    logic [7:0]        tx_dato_r;
    logic              tx_start_r;
    logic              flat_r;
    logic              err_r;

    function automatic logic [7:0] byte_sel(input logic [WORD_W-1:0] w,
                                            input logic [IDX_W-1:0]  i);
        return w[8*i +: 8];
    endfunction

    assign bus.ready       = !hold_full;
    assign bus.tx_dato     = tx_dato_r;
    assign bus.tx_start    = tx_start_r;
    assign bus.busy        = (state != IDLE);
    assign bus.flat_comple = flat_r;
    assign bus.err         = err_r;

    // Holding buffer and byte serializer FSM; accept and move never collide
    // because accept needs hold_full=0 and the move needs hold_full=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            hold_full  <= 1'b0;
            shift      <= '0;
            byte_idx   <= '0;
            ack_cnt    <= '0;
            tx_dato_r  <= 8'h00;
            tx_start_r <= 1'b0;
            flat_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            flat_r     <= 1'b0;

            if (bus.data_valid && !hold_full) begin
                hold      <= bus.data_in;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shift      <= hold;
                        hold_full  <= 1'b0;
                        byte_idx   <= '0;
                        tx_dato_r  <= hold[7:0];
                        tx_start_r <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    ack_cnt <= '0;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                        if (ack_cnt == ACK_LAST) begin
                            // Transmitter never answered: drop the rest of the word.
                            err_r <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (!bus.tx_busy) begin
                        if (byte_idx == LAST_IDX) begin
                            flat_r <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            byte_idx   <= byte_idx + 1'b1;
                            tx_dato_r  <= byte_sel(shift, byte_idx + 1'b1);
                            tx_start_r <= 1'b1;
                            state      <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_palabra_a_bytes.sv
// Directed bench for palabra_a_bytes with a behavioural UART TX model.
`timescale 1ns/1ps
module tb_palabra_a_bytes;
    localparam int NBYTES   = 4;
    localparam int ACK_WAIT = 15;

    logic clk;
    logic rst;

    palabra_a_bytes_if #(.NBYTES(NBYTES)) bus ();

    palabra_a_bytes #(.NBYTES(NBYTES), .ACK_WAIT(ACK_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // TX model controls
    logic       dead     = 1'b0;
    logic       spur     = 1'b0;
    logic       slow_en  = 1'b0;
    logic [7:0] slow_byte = 8'h00;
    int         slow_len = 20;
    int         base_len = 3;

    // Monitor log
    logic [7:0] sent[$];
    int         tstart[$];
    int         tflat[$];
    int         flat_cnt = 0;
    int         dbl      = 0;
    int         unstable = 0;
    int         cyc      = 0;
    logic       prev_start = 1'b0;
    logic [7:0] cur_byte = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end

    // UART TX: raises busy the cycle after tx_start and holds it for a set length.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_start && !dead) begin
                int b;
                b = (slow_en && bus.tx_dato == slow_byte) ? slow_len : base_len;
                @(posedge clk);
                #1;
                bus.tx_busy = 1'b1;
                repeat (b) @(posedge clk);
                #1;
                bus.tx_busy = 1'b0;
            end else begin
                bus.tx_busy = spur;
            end
        end
    end

    // Observes the byte stream on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.tx_start) begin
                sent.push_back(bus.tx_dato);
                tstart.push_back(cyc);
                cur_byte = bus.tx_dato;
                if (prev_start) dbl++;
            end else if (bus.busy && bus.tx_dato != cur_byte) begin
                unstable++;
            end
            if (bus.flat_comple) begin
                flat_cnt++;
                tflat.push_back(cyc);
            end
            prev_start = bus.tx_start;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        sent.delete();
        tstart.delete();
        tflat.delete();
        flat_cnt = 0;
    endtask

    // Offers a word, waits for ready, and returns just after the accepting edge.
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        while (!bus.ready && n < 200) begin
            step();
            n++;
        end
        check("accept_wait", 32'(n < 200), 32'd1);
        step();
        bus.data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while ((bus.busy || !bus.ready) && n < maxc) begin
            step();
            n++;
        end
        check(tag, 32'(n < maxc), 32'd1);
        step();
    endtask

    int n_before;
    int f_before;
    int k;

    initial begin
        rst            = 1'b1;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        repeat (2) step();

        // Reset state
        check("rst_ready",  32'(bus.ready), 32'd1);
        check("rst_start",  32'(bus.tx_start), 32'd0);
        check("rst_dato",   32'(bus.tx_dato), 32'h00);
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_flat",   32'(bus.flat_comple), 32'd0);
        check("rst_err",    32'(bus.err), 32'd0);
        rst = 1'b0;
        step();

        // Single word, busy 3 cycles per byte
        clear_log();
        send_word(32'hDDCCBBAA);
        check("lat_e0_start", 32'(bus.tx_start), 32'd0);
        check("lat_e0_ready", 32'(bus.ready), 32'd0);
        step();
        check("lat_e1_start", 32'(bus.tx_start), 32'd1);
        check("lat_e1_dato",  32'(bus.tx_dato), 32'hAA);
        check("lat_e1_busy",  32'(bus.busy), 32'd1);
        step();
        check("start_one_cycle", 32'(bus.tx_start), 32'd0);
        wait_idle("single_idle", 200);
        check("single_n",   32'(sent.size()), 32'd4);
        check("single_b0",  32'(sent[0]), 32'hAA);
        check("single_b1",  32'(sent[1]), 32'hBB);
        check("single_b2",  32'(sent[2]), 32'hCC);
        check("single_b3",  32'(sent[3]), 32'hDD);
        check("single_space", 32'(tstart[1] - tstart[0]), 32'd5);
        check("single_flat", 32'(flat_cnt), 32'd1);
        check("single_busy", 32'(bus.busy), 32'd0);
        check("single_err",  32'(bus.err), 32'd0);

        // Buffering: two words back to back, third offered while full
        clear_log();
        bus.data_in    = 32'h04030201;
        bus.data_valid = 1'b1;
        step();
        send_word(32'h08070605);
        check("buf_rdy_after_2nd", 32'(bus.ready), 32'd0);
        bus.data_in    = 32'hDEADBEEF;
        bus.data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("buf_rdy_full", 32'(bus.ready), 32'd0);
            step();
        end
        bus.data_valid = 1'b0;
        wait_idle("buf_idle", 300);
        check("buf_n", 32'(sent.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("buf_byte", 32'(sent[i]), 32'(i + 1));
        end
        check("buf_flat", 32'(flat_cnt), 32'd2);
        check("buf_gap", 32'(tstart[4] - tflat[0]), 32'd1);

        // Timeout: TX never answers
        clear_log();
        dead = 1'b1;
        send_word(32'hDDCCBBAA);
        step();
        check("to_start", 32'(bus.tx_start), 32'd1);
        check("to_dato",  32'(bus.tx_dato), 32'hAA);
        step();
        repeat (ACK_WAIT - 1) step();
        check("to_err_early", 32'(bus.err), 32'd0);
        step();
        check("to_err",  32'(bus.err), 32'd1);
        check("to_idle", 32'(bus.busy), 32'd0);
        check("to_n",    32'(sent.size()), 32'd1);
        check("to_flat", 32'(flat_cnt), 32'd0);
        dead = 1'b0;
        step();
        send_word(32'h0D0C0B0A);
        wait_idle("to_next_idle", 200);
        check("to_next_n",  32'(sent.size()), 32'd5);
        check("to_next_b0", 32'(sent[1]), 32'h0A);
        check("to_next_b3", 32'(sent[4]), 32'h0D);
        check("to_next_flat", 32'(flat_cnt), 32'd1);
        check("to_err_sticky", 32'(bus.err), 32'd1);

        // Reset in WAIT_IDLE of byte 2 with a word held
        clear_log();
        send_word(32'h14131211);
        send_word(32'h24232221);
        k = 0;
        while (!(bus.tx_start && bus.tx_dato == 8'h13) && k < 100) begin
            step();
            k++;
        end
        check("mid_reach", 32'(k < 100), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        check("mid_start", 32'(bus.tx_start), 32'd0);
        check("mid_dato",  32'(bus.tx_dato), 32'h00);
        check("mid_busy",  32'(bus.busy), 32'd0);
        check("mid_flat",  32'(bus.flat_comple), 32'd0);
        check("mid_err",   32'(bus.err), 32'd0);
        check("mid_ready", 32'(bus.ready), 32'd1);
        rst = 1'b0;
        n_before = sent.size();
        f_before = flat_cnt;
        repeat (20) step();
        check("mid_no_start", 32'(sent.size()), 32'(n_before));
        check("mid_no_flat",  32'(flat_cnt), 32'(f_before));

        // Slow byte 1, immediate release on the others
        clear_log();
        base_len  = 1;
        slow_en   = 1'b1;
        slow_byte = 8'h22;
        slow_len  = 20;
        send_word(32'h44332211);
        wait_idle("slow_idle", 300);
        check("slow_n",  32'(sent.size()), 32'd4);
        check("slow_b0", 32'(sent[0]), 32'h11);
        check("slow_b1", 32'(sent[1]), 32'h22);
        check("slow_b2", 32'(sent[2]), 32'h33);
        check("slow_b3", 32'(sent[3]), 32'h44);
        check("slow_sp0", 32'(tstart[1] - tstart[0]), 32'd3);
        check("slow_sp1", 32'(tstart[2] - tstart[1]), 32'd22);
        check("slow_flat", 32'(flat_cnt), 32'd1);
        check("slow_stable", 32'(unstable), 32'd0);
        slow_en  = 1'b0;
        base_len = 3;

        // Spurious busy while idle
        clear_log();
        spur = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin
            check("spur_idle_busy",  32'(bus.busy), 32'd0);
            check("spur_idle_start", 32'(bus.tx_start), 32'd0);
            step();
        end
        send_word(32'h5A6B7C8D);
        check("spur_e0_busy", 32'(bus.busy), 32'd0);
        step();
        check("spur_start", 32'(bus.tx_start), 32'd1);
        check("spur_dato",  32'(bus.tx_dato), 32'h8D);
        check("spur_no_flat", 32'(flat_cnt), 32'd0);
        spur = 1'b0;
        wait_idle("spur_idle", 200);
        check("spur_n",  32'(sent.size()), 32'd4);
        check("spur_b1", 32'(sent[1]), 32'h7C);
        check("spur_b3", 32'(sent[3]), 32'h5A);
        check("spur_flat", 32'(flat_cnt), 32'd1);

        check("no_double_start", 32'(dbl), 32'd0);
        check("dato_stable", 32'(unstable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
